z80_bus_responder: RTL and testbench
====================================

Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 8: log2 of internal RAM bytes; address bits above it alias.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, range 1-15: wait states inserted per access.
REQ-003 SHALL have parameter IO_PORT, default 8'h10: the single I/O port decoded on addr[7:0].
REQ-004 SHALL have parameter IM2_VECTOR, default 8'hFE: data returned in the interrupt-acknowledge cycle.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports addr input 16, dout input 8, mreq_n/iorq_n/rd_n/wr_n/m1_n input 1 each: CPU-side bus, active-low strobes.
REQ-008 SHALL have ports di output 8 (read data to CPU), wait_n output 1, int_n output 1.
REQ-009 SHALL have ports irq_req input 1 (host interrupt request pulse), io_in input 8, io_out output 8, err output 1 (sticky protocol error).

Function
REQ-010 SHALL implement FSM states IDLE, WAIT, ACCESS, HOLD; all outputs registered.
REQ-011 IDLE: on sampled (mreq_n=0 or iorq_n=0) with (rd_n=0 or wr_n=0), or intack (m1_n=0 and iorq_n=0), SHALL latch addr/dout/type and go WAIT, driving wait_n=0 from the next cycle.
REQ-012 WAIT SHALL hold wait_n=0 for exactly WAIT_CYCLES clocks (4-bit down-counter), then go ACCESS.
REQ-013 ACCESS (one cycle) SHALL perform the transaction, set wait_n=1, go HOLD.
REQ-014 Memory read: di = RAM[addr[MEM_AW-1:0]]; memory write: RAM written with latched dout exactly once per transaction.
REQ-015 I/O read of IO_PORT: di = io_in; other ports: di = 8'hFF; I/O write of IO_PORT: io_out = dout; other ports: no effect.
REQ-016 Intack: di = IM2_VECTOR, int_n released to 1 in ACCESS.
REQ-017 HOLD SHALL keep di stable until mreq_n, iorq_n, rd_n, wr_n all 1, then go IDLE with di = 8'hFF.
REQ-018 mreq_n=0 and iorq_n=0 both low with m1_n=1, or rd_n=0 and wr_n=0 both low, at detection SHALL set err=1, perform no access, go HOLD without wait states.
REQ-019 irq_req=1 SHALL set a pending flag; int_n = not pending; an irq_req coinciding with the ACCESS of an intack SHALL leave the flag set (int_n returns low next cycle).
REQ-020 err SHALL stay 1 until reset.
REQ-021 Strobes changing during WAIT/ACCESS SHALL not alter the latched transaction.

Reset
REQ-022 reset SHALL force wait_n=1, int_n=1, di=8'hFF, io_out=8'h00, err=0, pending=0, counter=0.
REQ-023 reset SHALL put the FSM in HOLD, so a strobe active at reset release is ignored until the bus idles.
REQ-024 RAM contents SHALL NOT be cleared by reset.
REQ-025 reset asserted mid-WAIT SHALL abort the transaction with no RAM/io_out write.

Configuration
REQ-026 Macro Z80_RESP_WAIT_EN defined: wait states per REQ-012.
REQ-027 Z80_RESP_WAIT_EN undefined: WAIT state and counter compiled out; IDLE goes directly to ACCESS; wait_n constant 1; latency one cycle shorter by WAIT_CYCLES.

Verification
REQ-028 Write 8'hA5 to mem 16'h0042, then read 16'h0142 (alias, MEM_AW=8) -> di=8'hA5, wait_n low exactly 2 clocks per access (macro defined).
REQ-029 I/O write 8'h3C to port 8'h10, I/O read port 8'h11 with io_in=8'h77 -> io_out=8'h3C, di=8'hFF; read port 8'h10 -> di=8'h77.
REQ-030 irq_req pulse -> int_n=0 next cycle; intack cycle -> di=8'hFE, int_n=1 after ACCESS; irq_req in that ACCESS cycle -> int_n=0 one cycle later.
REQ-031 mreq_n=0, iorq_n=0, m1_n=1, rd_n=0 -> err=1, wait_n stays 1, di=8'hFF, no RAM change.
REQ-032 reset asserted during WAIT of write 8'h11 to 16'h0005, strobes held through release -> no transaction until strobes idle, RAM[5] unchanged, outputs at reset values.
REQ-033 Build without Z80_RESP_WAIT_EN, repeat REQ-028 -> wait_n never 0, di valid one cycle after detection.

Source files
------------

// File: rtl/z80_bus_responder_if.sv
// CPU-side Z80 bus bundle for z80_bus_responder: address, write data and
// active-low strobes from the CPU; read data, wait and interrupt back to it.
interface z80_bus_responder_if;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic [7:0]  di;
    logic        wait_n;
    logic        int_n;

    modport master (
        output addr, dout, mreq_n, iorq_n, rd_n, wr_n, m1_n,
        input  di, wait_n, int_n
    );

    modport slave (
        input  addr, dout, mreq_n, iorq_n, rd_n, wr_n, m1_n,
        output di, wait_n, int_n
    );
endinterface

// File: rtl/z80_bus_responder.sv
// Z80 bus slave: internal RAM, one I/O port and IM2 interrupt acknowledge.
// Define Z80_RESP_WAIT_EN to insert WAIT_CYCLES wait states per access.
//
// state  | meaning
// IDLE   | bus idle, waiting for a strobe
// WAIT   | wait_n held low, counting wait states
// ACCESS | perform latched transaction
// HOLD   | keep di until all strobes released
module z80_bus_responder #(
    parameter int         MEM_AW      = 8,
    parameter int         WAIT_CYCLES = 2,
    parameter logic [7:0] IO_PORT     = 8'h10,
    parameter logic [7:0] IM2_VECTOR  = 8'hFE
) (
    input  logic                clk,
    input  logic                reset,
    z80_bus_responder_if.slave  bus,
    input  logic                irq_req,
    input  logic [7:0]          io_in,
    output logic [7:0]          io_out,
    output logic                err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;
    typedef enum logic [2:0] {TR_MEM_RD, TR_MEM_WR, TR_IO_RD, TR_IO_WR, TR_INTACK} trans_t;

    logic [7:0] mem [0:(1<<MEM_AW)-1];

    state_t            state_q, state_d;
    trans_t            trans_q, trans_d;
    logic [MEM_AW-1:0] maddr_q, maddr_d;
    logic [7:0]        port_q, port_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        di_q, di_d;
    logic [7:0]        io_out_q, io_out_d;
    logic              err_q, err_d;
    logic              pending_q, pending_d;
    logic              int_n_q, int_n_d;
    logic              mem_we, int_release;
`ifdef Z80_RESP_WAIT_EN
    logic              wait_n_q, wait_n_d;
    logic [3:0]        cnt_q, cnt_d;
`endif

    logic mreq, iorq, rd, wr, intack, req_any, req_err, bus_idle;

    assign mreq     = ~bus.mreq_n;
    assign iorq     = ~bus.iorq_n;
    assign rd       = ~bus.rd_n;
    assign wr       = ~bus.wr_n;
    assign intack   = ~bus.m1_n & iorq;
    assign req_any  = ((mreq | iorq) & (rd | wr)) | intack;
    assign req_err  = (mreq & iorq & bus.m1_n) | (rd & wr);
    assign bus_idle = bus.mreq_n & bus.iorq_n & bus.rd_n & bus.wr_n;

    always_comb begin
        state_d     = state_q;
        trans_d     = trans_q;
        maddr_d     = maddr_q;
        port_d      = port_q;
        wdata_d     = wdata_q;
        di_d        = di_q;
        io_out_d    = io_out_q;
        err_d       = err_q;
        pending_d   = pending_q | irq_req;
        mem_we      = 1'b0;
        int_release = 1'b0;
`ifdef Z80_RESP_WAIT_EN
        wait_n_d    = wait_n_q;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_any && req_err) begin
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end else if (req_any) begin
                    maddr_d = bus.addr[MEM_AW-1:0];
                    port_d  = bus.addr[7:0];
                    wdata_d = bus.dout;
                    if (intack)    trans_d = TR_INTACK;
                    else if (mreq) trans_d = rd ? TR_MEM_RD : TR_MEM_WR;
                    else           trans_d = rd ? TR_IO_RD : TR_IO_WR;
`ifdef Z80_RESP_WAIT_EN
                    state_d  = S_WAIT;
                    wait_n_d = 1'b0;
                    cnt_d    = 4'(WAIT_CYCLES - 1);
`else
                    state_d  = S_ACCESS;
`endif
                end
            end
`ifdef Z80_RESP_WAIT_EN
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    cnt_d    = 4'd0;
                    state_d  = S_ACCESS;
                    wait_n_d = 1'b1;
                end
            end
`endif
            S_ACCESS: begin
                state_d = S_HOLD;
                case (trans_q)
                    TR_MEM_RD: di_d = mem[maddr_q];
                    TR_MEM_WR: mem_we = 1'b1;
                    TR_IO_RD:  di_d = (port_q == IO_PORT) ? io_in : 8'hFF;
                    TR_IO_WR:  if (port_q == IO_PORT) io_out_d = wdata_q;
                    TR_INTACK: begin
                        di_d        = IM2_VECTOR;
                        pending_d   = irq_req;
                        int_release = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HOLD: begin
                if (bus_idle) begin
                    state_d = S_IDLE;
                    di_d    = 8'hFF;
                end
            end
            default: state_d = S_HOLD;
        endcase
        // acknowledge releases int_n for one cycle even if a new request arrives
        int_n_d = int_release ? 1'b1 : ~pending_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_HOLD;
            trans_q   <= TR_MEM_RD;
            maddr_q   <= '0;
            port_q    <= 8'h00;
            wdata_q   <= 8'h00;
            di_q      <= 8'hFF;
            io_out_q  <= 8'h00;
            err_q     <= 1'b0;
            pending_q <= 1'b0;
            int_n_q   <= 1'b1;
`ifdef Z80_RESP_WAIT_EN
            wait_n_q  <= 1'b1;
            cnt_q     <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            trans_q   <= trans_d;
            maddr_q   <= maddr_d;
            port_q    <= port_d;
            wdata_q   <= wdata_d;
            di_q      <= di_d;
            io_out_q  <= io_out_d;
            err_q     <= err_d;
            pending_q <= pending_d;
            int_n_q   <= int_n_d;
`ifdef Z80_RESP_WAIT_EN
            wait_n_q  <= wait_n_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    // RAM survives reset; a reset landing on ACCESS cancels the write
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem[maddr_q] <= wdata_q;
    end

    assign bus.di    = di_q;
    assign bus.int_n = int_n_q;
`ifdef Z80_RESP_WAIT_EN
    assign bus.wait_n = wait_n_q;
`else
    assign bus.wait_n = 1'b1;
`endif
    assign io_out = io_out_q;
    assign err    = err_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Bench for z80_bus_responder: vector table plus interrupt, error and reset
// sequences; expected read data is queued at drive time and popped at output.
module tb_z80_bus_responder;
    localparam int W = 2;
`ifdef Z80_RESP_WAIT_EN
    localparam int WEFF = W;
`else
    localparam int WEFF = 0;
`endif
    localparam int LAT = WEFF + 2;

    typedef enum logic [2:0] {K_MRD, K_MWR, K_IORD, K_IOWR, K_INTA} kind_t;
    typedef struct {
        kind_t       kind;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  io;
        logic [7:0]  exp_di;
        logic [7:0]  exp_io_out;
        logic        irq_acc;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       irq_req = 1'b0;
    logic [7:0] io_in = 8'h00;
    logic [7:0] io_out;
    logic       err;

    z80_bus_responder_if bus ();

    z80_bus_responder #(
        .MEM_AW(8), .WAIT_CYCLES(W), .IO_PORT(8'h10), .IM2_VECTOR(8'hFE)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .irq_req(irq_req),
        .io_in(io_in), .io_out(io_out), .err(err)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    vec_t       tbl [12];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic release_bus();
        bus.mreq_n = 1'b1; bus.iorq_n = 1'b1; bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;   bus.m1_n = 1'b1;
    endtask

    task automatic drive(input vec_t v);
        release_bus();
        bus.addr = v.addr;
        bus.dout = v.wdata;
        io_in    = v.io;
        case (v.kind)
            K_MRD:  begin bus.mreq_n = 1'b0; bus.rd_n = 1'b0; end
            K_MWR:  begin bus.mreq_n = 1'b0; bus.wr_n = 1'b0; end
            K_IORD: begin bus.iorq_n = 1'b0; bus.rd_n = 1'b0; end
            K_IOWR: begin bus.iorq_n = 1'b0; bus.wr_n = 1'b0; end
            K_INTA: begin bus.iorq_n = 1'b0; bus.m1_n = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic run_vec(input vec_t v);
        int         lows;
        logic [7:0] e;
        @(negedge clk);
        drive(v);
        exp_q.push_back(v.exp_di);
        lows = 0;
        for (int i = 1; i <= LAT + 1; i++) begin
            @(posedge clk); #1;
            irq_req = 1'b0;
            if (!bus.wait_n) lows++;
            if (i == LAT - 1) check("di_before_access", {8'h00, bus.di}, 16'h00FF);
            if (i == LAT) begin
                e = exp_q.pop_front();
                check("di", {8'h00, bus.di}, {8'h00, e});
                if (v.kind == K_INTA) check("int_n_released", {15'h0, bus.int_n}, 16'h1);
            end
            if (i == LAT + 1 && v.kind == K_INTA)
                check("int_n_after_ack", {15'h0, bus.int_n}, v.irq_acc ? 16'h0 : 16'h1);
            if (v.irq_acc && i == LAT - 1) begin
                @(negedge clk);
                irq_req = 1'b1;
            end
        end
        check("di_held", {8'h00, bus.di}, {8'h00, v.exp_di});
        check("wait_low_cycles", 16'(lows), 16'(WEFF));
        check("io_out", {8'h00, io_out}, {8'h00, v.exp_io_out});
        @(negedge clk);
        release_bus();
        @(posedge clk); #1;
        check("di_idle", {8'h00, bus.di}, 16'h00FF);
    endtask

    task automatic err_seq(input logic both_rw);
        int lows;
        @(negedge clk);
        release_bus();
        bus.addr = 16'h0042; bus.dout = 8'h00;
        bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
        if (both_rw) bus.wr_n = 1'b0;
        else         bus.iorq_n = 1'b0;
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (!bus.wait_n) lows++;
        end
        check("err_set", {15'h0, err}, 16'h1);
        check("err_no_wait", 16'(lows), 16'h0);
        check("err_di", {8'h00, bus.di}, 16'h00FF);
        @(negedge clk);
        release_bus();
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;
        int   lows;
        tbl[0]  = '{K_MWR,  16'h0042, 8'hA5, 8'h00, 8'hFF, 8'h00, 1'b0};
        tbl[1]  = '{K_MRD,  16'h0142, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b0};
        tbl[2]  = '{K_MWR,  16'h00FF, 8'h5A, 8'h00, 8'hFF, 8'h00, 1'b0};
        tbl[3]  = '{K_MRD,  16'h0FFF, 8'h00, 8'h00, 8'h5A, 8'h00, 1'b0};
        tbl[4]  = '{K_MWR,  16'h0005, 8'h66, 8'h00, 8'hFF, 8'h00, 1'b0};
        tbl[5]  = '{K_MRD,  16'h0005, 8'h00, 8'h00, 8'h66, 8'h00, 1'b0};
        tbl[6]  = '{K_IOWR, 16'h0010, 8'h3C, 8'h00, 8'hFF, 8'h3C, 1'b0};
        tbl[7]  = '{K_IORD, 16'h0011, 8'h00, 8'h77, 8'hFF, 8'h3C, 1'b0};
        tbl[8]  = '{K_IORD, 16'h0010, 8'h00, 8'h77, 8'h77, 8'h3C, 1'b0};
        tbl[9]  = '{K_IOWR, 16'h0011, 8'h99, 8'h00, 8'hFF, 8'h3C, 1'b0};
        tbl[10] = '{K_IORD, 16'h1210, 8'h00, 8'h44, 8'h44, 8'h3C, 1'b0};
        tbl[11] = '{K_MRD,  16'h0042, 8'h00, 8'h00, 8'hA5, 8'h3C, 1'b0};

        release_bus();
        bus.addr = 16'h0000; bus.dout = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wait_n", {15'h0, bus.wait_n}, 16'h1);
        check("rst_int_n", {15'h0, bus.int_n}, 16'h1);
        check("rst_di", {8'h00, bus.di}, 16'h00FF);
        check("rst_io_out", {8'h00, io_out}, 16'h0000);
        check("rst_err", {15'h0, err}, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 12; k++) run_vec(tbl[k]);
        check("err_clear_before_fault", {15'h0, err}, 16'h0);

        // interrupt request and acknowledge
        @(negedge clk); irq_req = 1'b1;
        @(posedge clk); #1; irq_req = 1'b0;
        check("irq_int_n_low", {15'h0, bus.int_n}, 16'h0);
        v = '{K_INTA, 16'h0000, 8'h00, 8'h00, 8'hFE, 8'h3C, 1'b0};
        run_vec(v);
        @(negedge clk); irq_req = 1'b1;
        @(posedge clk); #1; irq_req = 1'b0;
        check("irq2_int_n_low", {15'h0, bus.int_n}, 16'h0);
        v.irq_acc = 1'b1;
        run_vec(v);
        check("irq_still_pending", {15'h0, bus.int_n}, 16'h0);

        // protocol errors: no access, err sticky
        err_seq(1'b0);
        err_seq(1'b1);
        check("err_sticky", {15'h0, err}, 16'h1);

        // reset during a pending write, strobes held through release
        @(negedge clk);
        v = '{K_MWR, 16'h0005, 8'h11, 8'h00, 8'hFF, 8'h00, 1'b0};
        drive(v);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_di", {8'h00, bus.di}, 16'h00FF);
        check("mid_rst_io_out", {8'h00, io_out}, 16'h0000);
        check("mid_rst_err", {15'h0, err}, 16'h0);
        check("mid_rst_int_n", {15'h0, bus.int_n}, 16'h1);
        @(negedge clk);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (!bus.wait_n) lows++;
        end
        check("held_strobe_no_wait", 16'(lows), 16'h0);
        check("held_strobe_di", {8'h00, bus.di}, 16'h00FF);
        @(negedge clk);
        release_bus();
        @(posedge clk); #1;

        run_vec('{K_MRD, 16'h0005, 8'h00, 8'h00, 8'h66, 8'h00, 1'b0});
        run_vec('{K_MRD, 16'h0142, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b0});
        check("err_after_reset", {15'h0, err}, 16'h0);
        check("scoreboard_empty", 16'(exp_q.size()), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
